// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the time-multiplexed FIR (fir_tdm_mac).
// Contents:
//   state_t    - controller states IDLE -> MAC -> OUT
//   acc_width  - accumulator width: full-precision product plus clog2(N) guard bits
//   ptr_width  - width of the history / tap indices (at least 1 bit)
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    function automatic int acc_width(input int dw, input int cw, input int n);
        return dw + cw + $clog2(n);
    endfunction

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational scaling stage for fir_tdm_mac: arithmetic shift by FRAC, then clip
// to the signed DW-bit range.
// Optional rounding: define FIR_ROUND_EN to add 2^(FRAC-1) before the shift
// (round half up); otherwise the shift truncates toward minus infinity.
// Ports:
//   acc    in  ACCW  signed accumulator value
//   result out DW    scaled, saturated sample
//   sat    out 1     result was clipped
module fir_round_sat #(
    parameter int DW   = 32,
    parameter int FRAC = 31,
    parameter int ACCW = 71
) (
    input  logic signed [ACCW-1:0] acc,
    output logic signed [DW-1:0]   result,
    output logic                   sat
);

    // One guard bit above ACCW keeps the rounding add from wrapping.
    localparam logic signed [ACCW:0] MAXV = {{(ACCW + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [ACCW:0] MINV = {{(ACCW + 2 - DW){1'b1}}, {(DW - 1){1'b0}}};
`ifdef FIR_ROUND_EN
    localparam logic signed [ACCW:0] HALF =
        (FRAC > 0) ? ((ACCW + 1)'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
`endif

    logic signed [ACCW:0] biased;
    logic signed [ACCW:0] shifted;

    always_comb begin
        biased = {acc[ACCW-1], acc};
`ifdef FIR_ROUND_EN
        biased = biased + HALF;
`endif
        shifted = biased >>> FRAC;
        result  = shifted[DW-1:0];
        sat     = 1'b0;
        if (shifted > MAXV) begin
            result = MAXV[DW-1:0];
            sat    = 1'b1;
        end else if (shifted < MINV) begin
            result = MINV[DW-1:0];
            sat    = 1'b1;
        end
    end

endmodule

// File: rtl/fir_tdm_mac.sv
// Folded FIR filter: a single multiplier and accumulator walk all N taps, one tap
// per clock, over a circular sample history. Valid/ready handshake on both sides.
// Optional rounding via macro FIR_ROUND_EN (see fir_round_sat).
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   input handshake (ready only in IDLE)
//   in_data   [DW]      signed sample x[n]
//   coeffs    [CW] x N  coeffs[k] multiplies x[n-k]; held stable while busy
//   out_valid/out_ready output handshake
//   out_data  [DW]      signed y[n], stable while out_valid
//   out_sat             y[n] was clipped
//   busy                controller not in IDLE
module fir_tdm_mac
    import fir_pkg::*;
#(
    parameter int N    = 100,
    parameter int DW   = 32,
    parameter int CW   = 32,
    parameter int FRAC = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic signed [CW-1:0] coeffs [N],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_sat,
    output logic                 busy
);

    localparam int ACCW = acc_width(DW, CW, N);
    localparam int AW   = ptr_width(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t state, next_state;

    logic signed [DW-1:0]    hist [N];
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;
    logic [AW-1:0]           k;
    logic signed [ACCW-1:0]  acc;
    logic signed [ACCW-1:0]  acc_sum;
    logic signed [DW+CW-1:0] prod;
    logic signed [DW-1:0]    res;
    logic                    res_sat;
    logic                    accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    assign prod    = hist[rptr] * coeffs[k];
    assign acc_sum = acc + ACCW'(prod);

    // Scaling sees the sum including the final tap so the result can be
    // registered on the same edge that enters OUT.
    fir_round_sat #(
        .DW  (DW),
        .FRAC(FRAC),
        .ACCW(ACCW)
    ) u_round_sat (
        .acc   (acc_sum),
        .result(res),
        .sat   (res_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = MAC;
            MAC:     if (k == LAST) next_state = OUT;
            OUT:     if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) hist[i] <= '0;
            wptr     <= '0;
            rptr     <= '0;
            k        <= '0;
            acc      <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hist[wptr] <= in_data;
                        rptr       <= wptr;
                        wptr       <= (wptr == LAST) ? '0 : wptr + 1'b1;
                        k          <= '0;
                        acc        <= '0;
                    end
                end
                MAC: begin
                    acc  <= acc_sum;
                    k    <= k + 1'b1;
                    // Walk backwards from the newest slot: x[n], x[n-1], ...
                    rptr <= (rptr == '0) ? LAST : rptr - 1'b1;
                    if (k == LAST) begin
                        out_data <= res;
                        out_sat  <= res_sat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
